// File: rtl/i2c_xfer_sequencer_if.sv
// Request/response handshake plus the Wishbone master bus
// between the transfer sequencer and the I2C core.
interface i2c_xfer_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       wbm_cyc_o;
    logic       wbm_stb_o;
    logic       wbm_we_o;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_ack_i;

    modport master (
        input  req_valid,
        input  req_rd,
        input  req_dev,
        input  req_reg,
        input  req_wdata,
        input  wbm_dat_i,
        input  wbm_ack_i,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_adr_o,
        output wbm_dat_o
    );

    modport slave (
        output req_valid,
        output req_rd,
        output req_dev,
        output req_reg,
        output req_wdata,
        output wbm_dat_i,
        output wbm_ack_i,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_adr_o,
        input  wbm_dat_o
    );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// Drives an OpenCores-style I2C master over Wishbone to run
// single-byte register reads and writes on an I2C slave.
module i2c_xfer_sequencer #(
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter logic [15:0] POLL_MAX = 16'd65535
) (
    input  logic wb_clk_i,
    input  logic arst_i,
    i2c_xfer_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        INIT, IDLE, WB_WR, WB_RD,
        POLL, CHECK, STOP, DONE
    } state_t;

    typedef enum logic [1:0] {
        K_INIT, K_TXR, K_CR, K_STOP
    } kind_t;

    state_t      state;
    kind_t       kind;
    logic [1:0]  init_cnt;
    logic [2:0]  phase;
    logic [15:0] polls;
    logic        rd_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic        tip_q;
    logic        al_q;
    logic        rxack_q;
    logic [7:0]  rx_q;
    logic [1:0]  err_q;

    logic        ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_err;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  adr;
    logic [7:0]  dat;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.wbm_cyc_o = cyc;
    assign bus.wbm_stb_o = stb;
    assign bus.wbm_we_o  = we;
    assign bus.wbm_adr_o = adr;
    assign bus.wbm_dat_o = dat;

    function automatic logic [7:0] init_byte(
        input logic [1:0] n
    );
        unique case (n)
            2'd0:    return PRESCALE[7:0];
            2'd1:    return PRESCALE[15:8];
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] txr_byte(
        input logic [2:0] p
    );
        unique case (p)
            3'd0:    return {dev_q, 1'b0};
            3'd1:    return reg_q;
            3'd2:    return rd_q ? {dev_q, 1'b1} : wdata_q;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] cr_byte(
        input logic [2:0] p
    );
        unique case (p)
            3'd0:    return 8'h91;
            3'd1:    return 8'h11;
            3'd2:    return rd_q ? 8'h91 : 8'h51;
            default: return 8'h69;
        endcase
    endfunction

    logic [2:0] last_phase;
    assign last_phase = rd_q ? 3'd3 : 3'd2;

    // Every command is staged with cyc low; WB_WR/WB_RD raise
    // cyc one cycle later, which gives the idle gap between accesses.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state     <= INIT;
            kind      <= K_INIT;
            init_cnt  <= 2'd0;
            phase     <= 3'd0;
            polls     <= 16'd0;
            rd_q      <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'd0;
            wdata_q   <= 8'd0;
            tip_q     <= 1'b0;
            al_q      <= 1'b0;
            rxack_q   <= 1'b0;
            rx_q      <= 8'd0;
            err_q     <= 2'd0;
            ready     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_err   <= 2'd0;
            cyc       <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            adr       <= 3'd0;
            dat       <= 8'd0;
        end else begin
            unique case (state)
                INIT: begin
                    init_cnt <= 2'd0;
                    adr      <= 3'd0;
                    dat      <= init_byte(2'd0);
                    we       <= 1'b1;
                    kind     <= K_INIT;
                    state    <= WB_WR;
                end
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (ready && bus.req_valid) begin
                        ready   <= 1'b0;
                        rd_q    <= bus.req_rd;
                        dev_q   <= bus.req_dev;
                        reg_q   <= bus.req_reg;
                        wdata_q <= bus.req_wdata;
                        err_q   <= 2'd0;
                        phase   <= 3'd0;
                        adr     <= 3'd3;
                        dat     <= {bus.req_dev, 1'b0};
                        we      <= 1'b1;
                        kind    <= K_TXR;
                        state   <= WB_WR;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                WB_WR: begin
                    if (!cyc) begin
                        cyc <= 1'b1;
                        stb <= 1'b1;
                    end else if (bus.wbm_ack_i) begin
                        cyc <= 1'b0;
                        stb <= 1'b0;
                        unique case (kind)
                            K_INIT: begin
                                if (init_cnt == 2'd2) begin
                                    state <= IDLE;
                                end else begin
                                    init_cnt <= init_cnt + 2'd1;
                                    adr <= {1'b0, init_cnt + 2'd1};
                                    dat <= init_byte(init_cnt + 2'd1);
                                end
                            end
                            K_TXR: begin
                                adr  <= 3'd4;
                                dat  <= cr_byte(phase);
                                kind <= K_CR;
                            end
                            K_CR: begin
                                polls <= 16'd0;
                                state <= POLL;
                            end
                            K_STOP: state <= DONE;
                        endcase
                    end
                end
                POLL: begin
                    adr   <= 3'd4;
                    we    <= 1'b0;
                    polls <= polls + 16'd1;
                    state <= WB_RD;
                end
                WB_RD: begin
                    if (!cyc) begin
                        cyc <= 1'b1;
                        stb <= 1'b1;
                    end else if (bus.wbm_ack_i) begin
                        cyc <= 1'b0;
                        stb <= 1'b0;
                        if (phase == 3'd4) begin
                            rx_q  <= bus.wbm_dat_i;
                            state <= DONE;
                        end else begin
                            rxack_q <= bus.wbm_dat_i[7];
                            al_q    <= bus.wbm_dat_i[5];
                            tip_q   <= bus.wbm_dat_i[1];
                            state   <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (tip_q) begin
                        if (polls >= POLL_MAX) begin
                            err_q <= 2'b11;
                            state <= STOP;
                        end else begin
                            state <= POLL;
                        end
                    end else if (al_q) begin
                        err_q <= 2'b10;
                        state <= DONE;
                    end else if (rxack_q &&
                                 !(rd_q && phase == 3'd3)) begin
                        err_q <= 2'b01;
                        state <= STOP;
                    end else if (phase == last_phase) begin
                        if (rd_q) begin
                            phase <= 3'd4;
                            adr   <= 3'd3;
                            we    <= 1'b0;
                            state <= WB_RD;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        phase <= phase + 3'd1;
                        we    <= 1'b1;
                        state <= WB_WR;
                        // The final read phase has no TXR byte.
                        if (rd_q && phase == 3'd2) begin
                            adr  <= 3'd4;
                            dat  <= 8'h69;
                            kind <= K_CR;
                        end else begin
                            adr  <= 3'd3;
                            dat  <= txr_byte(phase + 3'd1);
                            kind <= K_TXR;
                        end
                    end
                end
                STOP: begin
                    adr   <= 3'd4;
                    dat   <= 8'h41;
                    we    <= 1'b1;
                    kind  <= K_STOP;
                    state <= WB_WR;
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (rd_q && err_q == 2'b00) ? rx_q : 8'h00;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench: an I2C core model answers the Wishbone bus and
// a monitor checks every bus write, RXR read and response.
module tb_i2c_xfer_sequencer;
    logic wb_clk_i = 1'b0;
    logic arst_i;

    always #5 wb_clk_i = ~wb_clk_i;

    i2c_xfer_sequencer_if bus();

    i2c_xfer_sequencer #(
        .PRESCALE(16'd99),
        .POLL_MAX(16'd4)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .arst_i  (arst_i),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0] err;
        logic [7:0] rdata;
        int         sr;
    } rsp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic [11:0] exp_wb[$];
    rsp_t        exp_rsp[$];
    chk_t        chk_q[$];

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;
    bit prev_rsp = 0;

    // Core model state
    int         cr_cnt = 0;
    int         sr_reads = 0;
    int         cr_base = 0;
    int         rd_base = 0;
    int         al_phase = -1;
    int         nack_phase = -1;
    bit         tip_stuck = 0;
    bit         busy = 0;
    logic [7:0] rx_byte = 8'h00;

    function automatic logic [7:0] sr_value();
        int ph;
        ph = cr_cnt - cr_base - 1;
        if (tip_stuck || busy) return 8'h02;
        if (ph == al_phase) return 8'h20;
        if (ph == nack_phase) return 8'h80;
        return 8'h00;
    endfunction

    initial begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 8'h00;
    end

    always @(posedge wb_clk_i) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) begin
            bus.wbm_ack_i <= 1'b1;
            if (!bus.wbm_we_o) begin
                if (bus.wbm_adr_o == 3'd4) begin
                    bus.wbm_dat_i <= sr_value();
                    sr_reads <= sr_reads + 1;
                    busy <= 1'b0;
                end else begin
                    bus.wbm_dat_i <= rx_byte;
                end
            end
        end else begin
            bus.wbm_ack_i <= 1'b0;
        end
        if (bus.wbm_ack_i && bus.wbm_cyc_o && bus.wbm_stb_o &&
            bus.wbm_we_o && bus.wbm_adr_o == 3'd4 &&
            bus.wbm_dat_o != 8'h41) begin
            cr_cnt <= cr_cnt + 1;
            busy <= 1'b1;
        end
    end

    task automatic compare(input string name,
                           input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    // Monitor: the only process that counts comparisons.
    always @(negedge wb_clk_i) begin
        logic [11:0] e;
        rsp_t r;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
        end
        if (prev_rsp) begin
            compare("rsp_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
            compare("ready_after_rsp", {31'd0, bus.req_ready}, 32'd1);
        end
        prev_rsp = arst_i && bus.rsp_valid;
        if (arst_i && bus.wbm_cyc_o && bus.wbm_stb_o &&
            bus.wbm_ack_i &&
            (bus.wbm_we_o || bus.wbm_adr_o == 3'd3)) begin
            if (exp_wb.size() == 0) begin
                compare("wb_unexpected",
                        {19'd0, bus.wbm_we_o, bus.wbm_adr_o,
                         bus.wbm_dat_o}, 32'hFFF);
            end else begin
                e = exp_wb.pop_front();
                if (!e[11]) begin
                    compare("wb_read",
                            {28'd0, bus.wbm_we_o, bus.wbm_adr_o},
                            {28'd0, e[11:8]});
                end else begin
                    compare("wb_write",
                            {20'd0, bus.wbm_we_o, bus.wbm_adr_o,
                             bus.wbm_dat_o},
                            {20'd0, e});
                end
            end
        end
        if (arst_i && bus.rsp_valid) begin
            rsp_cnt++;
            if (exp_rsp.size() == 0) begin
                compare("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                r = exp_rsp.pop_front();
                compare("rsp_err", {30'd0, bus.rsp_err},
                        {30'd0, r.err});
                compare("rsp_rdata", {24'd0, bus.rsp_rdata},
                        {24'd0, r.rdata});
                compare("rsp_ready_low", {31'd0, bus.req_ready},
                        32'd0);
                if (r.sr >= 0)
                    compare("sr_reads", sr_reads - rd_base, r.sr);
            end
        end
    end

    function automatic logic [31:0] outs();
        return {6'd0, bus.req_ready, bus.rsp_valid,
                bus.rsp_rdata, bus.rsp_err, bus.wbm_cyc_o,
                bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o,
                bus.wbm_dat_o};
    endfunction

    task automatic post(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic push_w(input logic [2:0] a, input logic [7:0] d);
        exp_wb.push_back({1'b1, a, d});
    endtask

    task automatic push_rsp(input logic [1:0] err,
                            input logic [7:0] rdata, input int sr);
        rsp_t r;
        r.err = err;
        r.rdata = rdata;
        r.sr = sr;
        exp_rsp.push_back(r);
    endtask

    task automatic push_init();
        push_w(3'd0, 8'h63);
        push_w(3'd1, 8'h00);
        push_w(3'd2, 8'h80);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.req_ready && n < 500) begin
            @(negedge wb_clk_i);
            n++;
        end
        post(name, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_req(input bit rd, input logic [6:0] dev,
                          input logic [7:0] rg,
                          input logic [7:0] wd);
        wait_ready("req_ready");
        cr_base = cr_cnt;
        rd_base = sr_reads;
        bus.req_rd = rd;
        bus.req_dev = dev;
        bus.req_reg = rg;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(posedge wb_clk_i);
        #1;
        bus.req_valid = 1'b0;
        bus.req_rd = ~rd;
        bus.req_dev = 7'h7F;
        bus.req_reg = 8'hEE;
        bus.req_wdata = 8'hDD;
    endtask

    task automatic wait_rsp(input string name);
        int start = rsp_cnt;
        int n = 0;
        while (rsp_cnt == start && n < 3000) begin
            @(negedge wb_clk_i);
            n++;
        end
        post({name, "_done"}, {31'd0, rsp_cnt != start}, 32'd1);
        repeat (2) @(negedge wb_clk_i);
        post({name, "_wb_left"}, exp_wb.size(), 32'd0);
    endtask

    initial begin
        int n;
        arst_i = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rd = 1'b0;
        bus.req_dev = 7'd0;
        bus.req_reg = 8'd0;
        bus.req_wdata = 8'd0;
        repeat (3) @(negedge wb_clk_i);
        post("reset_outputs", outs(), 32'd0);
        push_init();
        arst_i = 1'b1;
        wait_ready("init_ready");
        post("init_wb_left", exp_wb.size(), 32'd0);

        // Register write, all bytes ACKed
        push_w(3'd3, 8'hA0); push_w(3'd4, 8'h91);
        push_w(3'd3, 8'h10); push_w(3'd4, 8'h11);
        push_w(3'd3, 8'hA5); push_w(3'd4, 8'h51);
        push_rsp(2'b00, 8'h00, 6);
        do_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_rsp("write");

        // Register read; RxACK in the last phase must be ignored
        nack_phase = 3;
        rx_byte = 8'h3C;
        push_w(3'd3, 8'hA0); push_w(3'd4, 8'h91);
        push_w(3'd3, 8'h22); push_w(3'd4, 8'h11);
        push_w(3'd3, 8'hA1); push_w(3'd4, 8'h91);
        push_w(3'd4, 8'h69);
        exp_wb.push_back({1'b0, 3'd3, 8'h00});
        push_rsp(2'b00, 8'h3C, 8);
        do_req(1'b1, 7'h50, 8'h22, 8'h00);
        wait_rsp("read");

        // Address NACK
        nack_phase = 0;
        push_w(3'd3, 8'hA0); push_w(3'd4, 8'h91);
        push_w(3'd4, 8'h41);
        push_rsp(2'b01, 8'h00, 2);
        do_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_rsp("nack");

        // Arbitration lost in the second phase
        nack_phase = -1;
        al_phase = 1;
        push_w(3'd3, 8'h54); push_w(3'd4, 8'h91);
        push_w(3'd3, 8'h05); push_w(3'd4, 8'h11);
        push_rsp(2'b10, 8'h00, 4);
        do_req(1'b0, 7'h2A, 8'h05, 8'h77);
        wait_rsp("arb_lost");

        // TIP stuck: POLL_MAX reads then stop
        al_phase = -1;
        tip_stuck = 1'b1;
        push_w(3'd3, 8'hA0); push_w(3'd4, 8'h91);
        push_w(3'd4, 8'h41);
        push_rsp(2'b11, 8'h00, 4);
        do_req(1'b1, 7'h50, 8'h22, 8'h00);
        wait_rsp("timeout");
        tip_stuck = 1'b0;

        // Reset while stb is high during a read
        push_w(3'd3, 8'hA0); push_w(3'd4, 8'h91);
        do_req(1'b1, 7'h50, 8'h22, 8'h00);
        n = 0;
        while (!(bus.wbm_stb_o && !bus.wbm_we_o &&
                 !bus.wbm_ack_i) && n < 500) begin
            @(negedge wb_clk_i);
            n++;
        end
        post("abort_stb_seen", {31'd0, bus.wbm_stb_o}, 32'd1);
        arst_i = 1'b0;
        #1;
        post("abort_outputs", outs(), 32'd0);
        post("abort_wb_left", exp_wb.size(), 32'd0);
        repeat (3) @(negedge wb_clk_i);
        exp_wb.delete();
        push_init();
        arst_i = 1'b1;
        wait_ready("reinit_ready");
        post("reinit_wb_left", exp_wb.size(), 32'd0);

        // Normal write after the restart
        push_w(3'd3, 8'h22); push_w(3'd4, 8'h91);
        push_w(3'd3, 8'hFE); push_w(3'd4, 8'h11);
        push_w(3'd3, 8'h00); push_w(3'd4, 8'h51);
        push_rsp(2'b00, 8'h00, 6);
        do_req(1'b0, 7'h11, 8'hFE, 8'h00);
        wait_rsp("write2");
        post("rsp_left", exp_rsp.size(), 32'd0);

        repeat (5) @(negedge wb_clk_i);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
